// File: rtl/exanet_crosb_pkg.sv
// Shared types and constants for the crossbar output arbitration logic.
package exanet_crosb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int unsigned ARB_STARVE_SAT = 255;

endpackage

// File: rtl/exa_crosb_rr_picker.sv
// Combinational round-robin picker: first set bit of mask at or after ptr, wrapping.
module exa_crosb_rr_picker
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int unsigned pos;
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!any && mask[pos]) begin
        any         = 1'b1;
        winner[pos] = 1'b1;
        idx         = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/exa_crosb_out_arbiter.sv
// Per-output crossbar arbiter: two-class round-robin with starvation guard,
// grant held until tlast, watchdog forced release on a stalled packet.
module exa_crosb_out_arbiter
  import exanet_crosb_pkg::*;
#(
  parameter int unsigned IN_NUM      = 4,
  parameter int unsigned TDEST_WIDTH = 3,
  parameter int unsigned OUT_ID      = 0,
  parameter int unsigned STARVE_MAX  = 8,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CNT_W       = 11,
  localparam int unsigned IW = (IN_NUM > 1) ? $clog2(IN_NUM) : 1
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic [IN_NUM-1:0]             i_dest_valid,
  input  logic [IN_NUM*TDEST_WIDTH-1:0] i_tdest,
  input  logic [IN_NUM-1:0]             i_prio,
  input  logic                          i_out_tvalid,
  input  logic                          i_out_tready,
  input  logic                          i_out_tlast,
  output logic [IN_NUM-1:0]             o_grant,
  output logic [IW-1:0]                 o_grant_idx,
  output logic                          o_busy,
  output logic                          o_timeout,
  output logic [7:0]                    o_starve_cnt
);

  localparam logic [7:0]       STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0]       STARVE_SAT = 8'(ARB_STARVE_SAT);
  localparam bit               WD_EN      = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST    = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [IN_NUM-1:0] grant_q, grant_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              timeout_q, timeout_d;
  logic [IW-1:0]     ptr_hi_q, ptr_hi_d, ptr_lo_q, ptr_lo_d;
  logic [7:0]        starve_q, starve_d;
  logic [CNT_W-1:0]  wd_q, wd_d;

  logic [IN_NUM-1:0] req, hi, lo, hi_win, lo_win;
  logic [IW-1:0]     hi_idx, lo_idx;
  logic              hi_any, lo_any, pick_lo, beat;

  always_comb begin
    req = '0;
    for (int unsigned k = 0; k < IN_NUM; k++) begin
      req[k] = i_dest_valid[k] &&
               (i_tdest[k*TDEST_WIDTH +: TDEST_WIDTH] == TDEST_WIDTH'(OUT_ID));
    end
  end

  assign hi = req & i_prio;
  assign lo = req & ~i_prio;

  exa_crosb_rr_picker #(.N(IN_NUM)) u_pick_hi (
    .mask   (hi),
    .ptr    (ptr_hi_q),
    .winner (hi_win),
    .idx    (hi_idx),
    .any    (hi_any)
  );

  exa_crosb_rr_picker #(.N(IN_NUM)) u_pick_lo (
    .mask   (lo),
    .ptr    (ptr_lo_q),
    .winner (lo_win),
    .idx    (lo_idx),
    .any    (lo_any)
  );

  assign pick_lo = lo_any && (!hi_any || (starve_q >= STARVE_LIM));
  assign beat    = i_out_tvalid && i_out_tready;

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] w);
    return (32'(w) == IN_NUM - 1) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    ptr_hi_d  = ptr_hi_q;
    ptr_lo_d  = ptr_lo_q;
    starve_d  = starve_q;
    wd_d      = wd_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          state_d = ARB_BUSY;
          wd_d    = '0;
          if (pick_lo) begin
            grant_d  = lo_win;
            idx_d    = lo_idx;
            ptr_lo_d = ptr_after(lo_idx);
            starve_d = '0;
          end else begin
            grant_d  = hi_win;
            idx_d    = hi_idx;
            ptr_hi_d = ptr_after(hi_idx);
            // Only high grants that bypass a waiting low request count toward starvation
            if (!lo_any)                  starve_d = '0;
            else if (starve_q != STARVE_SAT) starve_d = starve_q + 8'd1;
          end
        end
      end
      ARB_BUSY: begin
        // tlast wins over a coincident watchdog expiry
        if (beat && i_out_tlast) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          idx_d   = '0;
          wd_d    = '0;
        end else if (beat) begin
          wd_d = '0;
        end else if (WD_EN && (wd_q == WD_LAST)) begin
          state_d   = ARB_IDLE;
          grant_d   = '0;
          idx_d     = '0;
          wd_d      = '0;
          timeout_d = 1'b1;
        end else if (WD_EN) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      timeout_q <= 1'b0;
      ptr_hi_q  <= '0;
      ptr_lo_q  <= '0;
      starve_q  <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
      ptr_hi_q  <= ptr_hi_d;
      ptr_lo_q  <= ptr_lo_d;
      starve_q  <= starve_d;
      wd_q      <= wd_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_grant_idx  = idx_q;
  assign o_busy       = (state_q == ARB_BUSY);
  assign o_timeout    = timeout_q;
  assign o_starve_cnt = starve_q;

endmodule

// File: tb/tb_exa_crosb_out_arbiter.sv
// Directed bench for exa_crosb_out_arbiter: vector table plus hand-written watchdog/reset sequences.
module tb_exa_crosb_out_arbiter;

  logic        Clk;
  logic        ResetN;
  logic [3:0]  dest_valid;
  logic [11:0] tdest;
  logic [3:0]  prio;
  logic        out_tvalid, out_tready, out_tlast;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        busy, timeout;
  logic [7:0]  starve_cnt;

  int errors = 0;
  int checks = 0;

  exa_crosb_out_arbiter #(
    .IN_NUM(4), .TDEST_WIDTH(3), .OUT_ID(0), .STARVE_MAX(2), .TIMEOUT(16), .CNT_W(11)
  ) dut (
    .Clk          (Clk),
    .ResetN       (ResetN),
    .i_dest_valid (dest_valid),
    .i_tdest      (tdest),
    .i_prio       (prio),
    .i_out_tvalid (out_tvalid),
    .i_out_tready (out_tready),
    .i_out_tlast  (out_tlast),
    .o_grant      (grant),
    .o_grant_idx  (grant_idx),
    .o_busy       (busy),
    .o_timeout    (timeout),
    .o_starve_cnt (starve_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic [3:0]  dv;
    logic [11:0] td;
    logic [3:0]  pr;
    logic        tv, tr, tl;
    logic [3:0]  g;
    logic [1:0]  idx;
    logic        b;
    logic        to;
    logic [7:0]  sc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic [3:0] dv, logic [11:0] td, logic [3:0] pr,
                              logic tv, logic tr, logic tl, logic [3:0] g, logic [1:0] idx,
                              logic b, logic [7:0] sc);
    vec_t v;
    v.rst = rst; v.dv = dv; v.td = td; v.pr = pr;
    v.tv = tv; v.tr = tr; v.tl = tl;
    v.g = g; v.idx = idx; v.b = b; v.to = 1'b0; v.sc = sc;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, n, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] dv, input logic [3:0] pr,
                        input logic tv, input logic tr, input logic tl);
    dest_valid = dv; tdest = '0; prio = pr;
    out_tvalid = tv; out_tready = tr; out_tlast = tl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    ResetN = 1'b0;
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    #3;
    chk("reset_grant", 0, 32'(grant), 32'h0);
    chk("reset_busy", 0, 32'(busy), 32'h0);
    chk("reset_idx", 0, 32'(grant_idx), 32'h0);
    chk("reset_timeout", 0, 32'(timeout), 32'h0);
    chk("reset_starve", 0, 32'(starve_cnt), 32'h0);
    tick(); tick();
    ResetN = 1'b1;

    // single requester, 3-beat packet; request drop while held is ignored
    add(0, 4'b0100, 12'h0, 4'b0000, 0, 0, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0100, 12'h0, 4'b0000, 1, 1, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 12'h0, 4'b0000, 1, 1, 0, 4'b0100, 2, 1, 0);
    add(0, 4'b0000, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b0000, 12'h0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0000, 12'h0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    // round robin among low inputs 0,1,3 with 1-beat packets
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b0001, 0, 1, 0);
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0);
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b0010, 1, 1, 0);
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0);
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b1000, 3, 1, 0);
      add(0, 4'b1011, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0);
    end
    // high inputs 0,2 vs low input 1, starvation limit 2
    for (int r = 0; r < 2; r++) begin
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0001, 0, 1, 1);
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0000, 0, 0, 1);
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0100, 2, 1, 2);
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0000, 0, 0, 2);
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0010, 1, 1, 0);
      add(0, 4'b0111, 12'h0, 4'b0101, 1, 1, 1, 4'b0000, 0, 0, 0);
    end
    // tdest filtering: input 0 addressed to output 1
    add(0, 4'b0001, 12'h001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    add(0, 4'b0001, 12'h001, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
    // no preemption by high class; tready gating; hi-only grant clears starvation
    add(0, 4'b0010, 12'h0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1011, 12'h0, 4'b1001, 0, 0, 0, 4'b0010, 1, 1, 0);
    add(0, 4'b1011, 12'h0, 4'b1001, 1, 0, 1, 4'b0010, 1, 1, 0);
    add(0, 4'b1011, 12'h0, 4'b1001, 1, 1, 1, 4'b0000, 0, 0, 0);
    add(0, 4'b1011, 12'h0, 4'b1001, 0, 0, 0, 4'b1000, 3, 1, 1);
    add(0, 4'b0000, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0001, 12'h0, 4'b0001, 0, 0, 0, 4'b0001, 0, 1, 0);
    add(0, 4'b0000, 12'h0, 4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      ResetN     = !vecs[i].rst;
      dest_valid = vecs[i].dv;
      tdest      = vecs[i].td;
      prio       = vecs[i].pr;
      out_tvalid = vecs[i].tv;
      out_tready = vecs[i].tr;
      out_tlast  = vecs[i].tl;
      tick();
      chk("grant", i, 32'(grant), 32'(vecs[i].g));
      chk("grant_idx", i, 32'(grant_idx), 32'(vecs[i].idx));
      chk("busy", i, 32'(busy), 32'(vecs[i].b));
      chk("timeout", i, 32'(timeout), 32'(vecs[i].to));
      chk("starve_cnt", i, 32'(starve_cnt), 32'(vecs[i].sc));
    end
    ResetN = 1'b1;

    // watchdog: input 3 stalls, released 16 cycles after grant
    set_in(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("wd_grant", 100, 32'(grant), 32'h8);
    set_in(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("wd_hold", 100 + i, 32'(grant), 32'h8);
      chk("wd_no_pulse", 100 + i, 32'(timeout), 32'h0);
    end
    tick();
    chk("wd_pulse", 116, 32'(timeout), 32'h1);
    chk("wd_release", 116, 32'(grant), 32'h0);
    chk("wd_busy", 116, 32'(busy), 32'h0);
    tick();
    chk("wd_next_winner", 117, 32'(grant), 32'h1);
    chk("wd_pulse_end", 117, 32'(timeout), 32'h0);

    // tlast on the expiry cycle is a normal release
    set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 15; i++) tick();
    chk("edge_hold", 131, 32'(grant), 32'h1);
    set_in(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    tick();
    chk("edge_release", 132, 32'(grant), 32'h0);
    chk("edge_no_pulse", 132, 32'(timeout), 32'h0);

    // async reset mid-packet, then pointers back at 0
    set_in(4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_grant", 140, 32'(grant), 32'h4);
    #2 ResetN = 1'b0;
    #1;
    chk("ar_grant_clr", 141, 32'(grant), 32'h0);
    chk("ar_busy_clr", 141, 32'(busy), 32'h0);
    chk("ar_idx_clr", 141, 32'(grant_idx), 32'h0);
    #1 ResetN = 1'b1;
    set_in(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("ar_first_grant", 142, 32'(grant), 32'h2);
    chk("ar_first_idx", 142, 32'(grant_idx), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exa_crosb_out_arbiter.md
Name: exa_crosb_out_arbiter

Overview:
Per-output-port arbiter for the crossbar. There is one instance per output. It collects routing decisions from all input ports' routing stages: dest_valid, tdest and prio. It grants the output to one input at a time and holds that grant until the packet's last beat has transferred. Priority is two-class: high class first, round-robin within each class, and a starvation guard protects the low class. A watchdog releases the grant if a packet stalls.

Parameters:
IN_NUM, 4, number of input ports competing for this output (2..32)
TDEST_WIDTH, 3, width of each input's tdest field
OUT_ID, 0, index of the output this instance serves; an input requests only when its tdest equals OUT_ID
STARVE_MAX, 8, number of consecutive high-class grants allowed while a low-class request is pending (1..255)
TIMEOUT, 1024, idle cycles in BUSY (no accepted beat) before forced release; 0 disables the watchdog
CNT_W, 11, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
Clk  in  1  clock
ResetN  in  1  reset, asynchronous, active-low
i_dest_valid  in  IN_NUM  per-input routing result valid
i_tdest  in  IN_NUM*TDEST_WIDTH  per-input destination, packed; input k occupies [k*TDEST_WIDTH +: TDEST_WIDTH]
i_prio  in  IN_NUM  per-input high-priority flag
i_out_tvalid  in  1  tvalid of the muxed stream at this output
i_out_tready  in  1  tready from the downstream of this output
i_out_tlast  in  1  tlast of the muxed stream
o_grant  out  IN_NUM  one-hot grant; drives the data mux select and the input tready gating
o_grant_idx  out  $clog2(IN_NUM)  binary index of the granted input
o_busy  out  1  a grant is held
o_timeout  out  1  one-cycle pulse on watchdog release
o_starve_cnt  out  8  current consecutive high-class grant count (debug)

Behaviour:
- Reset (ResetN low, asynchronous): state=IDLE; o_grant=0; o_grant_idx=0; o_busy=0; o_timeout=0; both RR pointers=0; starve_cnt=0; watchdog=0.
- Request vector: req[k] = i_dest_valid[k] & (tdest[k]==OUT_ID). hi = req & i_prio. lo = req & ~i_prio.
- States:
  - IDLE: if req is nonzero, pick a winner, register grant, go to BUSY. Grant is visible the cycle after the request is seen (1-cycle latency).
  - BUSY: hold o_grant stable. A beat is accepted when i_out_tvalid & i_out_tready.
    - Accepted beat with tlast=1: go to IDLE next cycle and clear o_grant.
    - Otherwise the grant is held.
- Re-arbitration takes one bubble cycle: the earliest new grant comes 2 cycles after the tlast beat.
- Class selection (at pick time):
  - Choose the low class if lo != 0 and (hi == 0 or starve_cnt >= STARVE_MAX). Otherwise choose the high class.
- Round-robin within a class:
  - Start at the class pointer and take the first set bit, with wrap from IN_NUM-1 to 0.
  - After a grant, that class's pointer = winner+1 mod IN_NUM. The other class's pointer is unchanged.
- Starvation counter:
  - High-class grant while lo != 0: increment, saturating at 255.
  - Low-class grant, or a high-class grant with lo == 0: clear to 0.
- Watchdog:
  - In BUSY, counts cycles with no accepted beat; it clears on every accepted beat and on entering BUSY.
  - When the count reaches TIMEOUT (TIMEOUT != 0): pulse o_timeout for 1 cycle, clear the grant, return to IDLE. The RR pointer keeps its post-grant value, so the stalled input is not re-favoured.
- Boundary cases:
  - A request that drops while granted is ignored; only tlast or timeout releases the grant.
  - A tlast beat in the same cycle as a watchdog expiry counts as a normal release; no timeout pulse.
  - A single-beat packet (tlast on the first beat) behaves like any packet.
  - Requests present while BUSY wait; there is no preemption, including by high priority.
- o_grant_idx is always consistent with o_grant; it is 0 when no grant is held.

Decomposition:
- exanet_crosb_pkg: arb_state_t enum {ARB_IDLE, ARB_BUSY}; localparam ARB_STARVE_SAT=255.
- Sub-module exa_crosb_rr_picker, combinational and parameterised by N:
  - Inputs: mask[N], ptr.
  - Outputs: one-hot winner, binary index, any.
  - Instantiated twice, once per class.
- The top level holds the FSM, pointers, starvation counter and watchdog.

Test Plan:
- Single requester: input 2 requests (tdest=OUT_ID=0, prio=0) in cycle 0 → o_grant=4'b0100 in cycle 1. A 3-beat packet with tlast on beat 3 → o_grant=0 the cycle after, o_busy=0.
- Round-robin fairness: inputs 0, 1 and 3 request continuously with prio=0 and 1-beat packets → grant order 0, 1, 3, 0, 1, 3, with one idle cycle between grants.
- Priority plus starvation (STARVE_MAX=2): input 1 low, inputs 0 and 2 high, all continuous → grant order 0, 2, 1, 0, 2, 1. o_starve_cnt shows 1, 2, 0.
- Watchdog (TIMEOUT=16): grant input 3, hold i_out_tvalid=0 → o_timeout pulses 16 cycles after grant, o_grant=0. If input 3 still requests, it does not win over pending input 0 on the next pick.
- Tdest filtering: input 0 requests with tdest=1 and OUT_ID=0 → no grant, o_busy stays 0.
- Async reset mid-packet: drop ResetN during BUSY, without a clock edge → o_grant=0 and o_busy=0 immediately. After release, the first grant goes to the lowest-index requester (pointer=0).
